// File: rtl/seven_seg_pkg.sv
// Shared types and helpers for the seven-segment scan controller.
//   scan_state_e : scan FSM states
//   SEG_OFF      : active-low segment word with every segment dark
//   cnt_width()  : slot counter width for a given pair of slot lengths
package seven_seg_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    SHOW  = 2'd2
  } scan_state_e;

  localparam logic [7:0] SEG_OFF = 8'hFF;

  // The counter must hold max(digit_ticks, blank_ticks) - 1 as a reload
  // value; sizing on max+1 keeps a spare code and never returns zero width.
  function automatic int unsigned cnt_width(input int unsigned digit_ticks,
                                            input int unsigned blank_ticks);
    int unsigned m;
    int unsigned w;
    m = (digit_ticks > blank_ticks) ? digit_ticks : blank_ticks;
    w = $clog2(m + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/seven_seg_scan_ctrl_dec.sv
// Hex nibble to seven-segment decoder (active-high segments).
//   nibble : hex digit 0..F
//   seg    : [6:0] = g..a, [7] = dp (always 0 here; the scan controller
//            owns the decimal point)
module nibble_to_seven_seg
  import seven_seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [7:0] seg
);

  always_comb begin
    seg = 8'h00;
    unique case (nibble)
      4'h0: seg = 8'h3F;
      4'h1: seg = 8'h06;
      4'h2: seg = 8'h5B;
      4'h3: seg = 8'h4F;
      4'h4: seg = 8'h66;
      4'h5: seg = 8'h6D;
      4'h6: seg = 8'h7D;
      4'h7: seg = 8'h07;
      4'h8: seg = 8'h7F;
      4'h9: seg = 8'h6F;
      4'hA: seg = 8'h77;
      4'hB: seg = 8'h7C;
      4'hC: seg = 8'h39;
      4'hD: seg = 8'h5E;
      4'hE: seg = 8'h79;
      4'hF: seg = 8'h71;
      default: seg = 8'h00;
    endcase
  end

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// Time-multiplexed scan controller for a common-anode seven-segment display.
// Display words arrive on a valid/ready port into a pending buffer and are
// promoted to the active buffer only at frame boundaries (or while idle).
//   clk, rst     : system clock, async active-high reset
//   enable       : scanning enabled
//   load_valid   : load request; load_ready : pending buffer free
//   value_in     : hex word, nibble i -> digit i
//   dp_in        : decimal point per digit (1 = lit)
//   lz_blank_en  : leading-zero blanking enable
//   seg_n        : active-low segments, [6:0] = g..a, [7] = dp
//   an_n         : active-low anode enables
//   digit_idx    : digit currently selected
//   frame_done   : one-cycle pulse on the frame wrap edge
//
// state | meaning
// IDLE  | scanning off, display dark, pending may promote every cycle
// BLANK | all anodes off before a digit (anti-ghosting)
// SHOW  | anode of digit_idx lit with its decoded segments
module seven_seg_scan_ctrl
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int DIGIT_TICKS = 1000,
  parameter int BLANK_TICKS = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable,
  input  logic                          load_valid,
  output logic                          load_ready,
  input  logic [4*NUM_DIGITS-1:0]       value_in,
  input  logic [NUM_DIGITS-1:0]         dp_in,
  input  logic                          lz_blank_en,
  output logic [7:0]                    seg_n,
  output logic [NUM_DIGITS-1:0]         an_n,
  output logic [$clog2(NUM_DIGITS)-1:0] digit_idx,
  output logic                          frame_done
);

  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam int CNT_W = cnt_width(DIGIT_TICKS, BLANK_TICKS);
  localparam bit HAS_BLANK = (BLANK_TICKS > 0);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);
  localparam logic [CNT_W-1:0] SHOW_LOAD = CNT_W'(DIGIT_TICKS - 1);
  localparam logic [CNT_W-1:0] BLANK_LOAD = CNT_W'(HAS_BLANK ? BLANK_TICKS - 1 : 0);

  scan_state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] digit_idx_q, digit_idx_d;
  logic frame_done_q, frame_done_d;
  logic [7:0] seg_n_q, seg_n_d;
  logic [NUM_DIGITS-1:0] an_n_q, an_n_d;

  logic [4*NUM_DIGITS-1:0] act_val_q, act_val_d, pend_val_q, pend_val_d;
  logic [NUM_DIGITS-1:0] act_dp_q, act_dp_d, pend_dp_q, pend_dp_d;
  logic act_lz_q, act_lz_d, pend_lz_q, pend_lz_d;
  logic pend_full_q, pend_full_d;

  logic load_fire;
  logic xfer;
  logic [4*NUM_DIGITS-1:0] src_val;
  logic [NUM_DIGITS-1:0] src_dp;
  logic src_lz;
  logic [NUM_DIGITS-1:0] zero_from;
  logic zero_run;
  logic [3:0] sel_nib;
  logic sel_dp;
  logic sel_zero;
  logic blank_sel;
  logic [7:0] dec_seg;
  logic unused_dec_dp;

  // ---------------------------------------------------------------------
  // Scan FSM: down-counting slot timer, reload on every slot change
  // ---------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    digit_idx_d  = digit_idx_q;
    frame_done_d = 1'b0;
    if (!enable) begin
      state_d     = IDLE;
      cnt_d       = '0;
      digit_idx_d = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          digit_idx_d = '0;
          if (HAS_BLANK) begin
            state_d = BLANK;
            cnt_d   = BLANK_LOAD;
          end else begin
            state_d = SHOW;
            cnt_d   = SHOW_LOAD;
          end
        end
        BLANK: begin
          if (cnt_q == '0) begin
            state_d = SHOW;
            cnt_d   = SHOW_LOAD;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        SHOW: begin
          if (cnt_q == '0) begin
            if (digit_idx_q == LAST_IDX) begin
              digit_idx_d  = '0;
              frame_done_d = 1'b1;
            end else begin
              digit_idx_d = digit_idx_q + 1'b1;
            end
            if (HAS_BLANK) begin
              state_d = BLANK;
              cnt_d   = BLANK_LOAD;
            end else begin
              state_d = SHOW;
              cnt_d   = SHOW_LOAD;
            end
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        default: begin
          state_d     = IDLE;
          cnt_d       = '0;
          digit_idx_d = '0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Load handshake and double buffer
  // ---------------------------------------------------------------------
  assign load_fire = load_valid && !pend_full_q;

  always_comb begin
    xfer = pend_full_q && (frame_done_d || (state_q == IDLE));
  end

  always_comb begin
    pend_val_d  = pend_val_q;
    pend_dp_d   = pend_dp_q;
    pend_lz_d   = pend_lz_q;
    pend_full_d = pend_full_q;
    act_val_d   = act_val_q;
    act_dp_d    = act_dp_q;
    act_lz_d    = act_lz_q;
    if (xfer) begin
      act_val_d   = pend_val_q;
      act_dp_d    = pend_dp_q;
      act_lz_d    = pend_lz_q;
      pend_full_d = 1'b0;
    end
    // A load can only fire while pending is empty, so it never collides
    // with a transfer of the same cycle.
    if (load_fire) begin
      pend_val_d  = value_in;
      pend_dp_d   = dp_in;
      pend_lz_d   = lz_blank_en;
      pend_full_d = 1'b1;
    end
  end

  // ---------------------------------------------------------------------
  // Segment path. The decoder looks at the digit selected after this edge.
  // On a transfer edge the word being promoted is what becomes active, so
  // decode from it; otherwise digit 0 of a BLANK-less frame would show the
  // stale word for its first slot.
  // ---------------------------------------------------------------------
  always_comb begin
    src_val = xfer ? pend_val_q : act_val_q;
    src_dp  = xfer ? pend_dp_q  : act_dp_q;
    src_lz  = xfer ? pend_lz_q  : act_lz_q;
  end

  always_comb begin
    zero_run  = 1'b1;
    zero_from = '0;
    sel_nib   = 4'h0;
    sel_dp    = 1'b0;
    sel_zero  = 1'b0;
    // zero_from[i]: nibble i and every nibble above it are zero
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_run     = zero_run && (src_val[i*4 +: 4] == 4'h0);
      zero_from[i] = zero_run;
    end
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (digit_idx_d == IDX_W'(i)) begin
        sel_nib  = src_val[i*4 +: 4];
        sel_dp   = src_dp[i];
        sel_zero = zero_from[i];
      end
    end
    blank_sel = src_lz && (digit_idx_d != '0) && sel_zero;
  end

  nibble_to_seven_seg u_dec (
    .nibble (sel_nib),
    .seg    (dec_seg)
  );

  assign unused_dec_dp = dec_seg[7];

  always_comb begin
    an_n_d  = '1;
    seg_n_d = SEG_OFF;
    if (state_d == SHOW) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (digit_idx_d == IDX_W'(i)) begin
          an_n_d[i] = 1'b0;
        end
      end
      seg_n_d = {~sel_dp, (blank_sel ? 7'h7F : ~dec_seg[6:0])};
    end
  end

  // ---------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      digit_idx_q  <= '0;
      frame_done_q <= 1'b0;
      seg_n_q      <= SEG_OFF;
      an_n_q       <= '1;
      act_val_q    <= '0;
      act_dp_q     <= '0;
      act_lz_q     <= 1'b0;
      pend_val_q   <= '0;
      pend_dp_q    <= '0;
      pend_lz_q    <= 1'b0;
      pend_full_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      digit_idx_q  <= digit_idx_d;
      frame_done_q <= frame_done_d;
      seg_n_q      <= seg_n_d;
      an_n_q       <= an_n_d;
      act_val_q    <= act_val_d;
      act_dp_q     <= act_dp_d;
      act_lz_q     <= act_lz_d;
      pend_val_q   <= pend_val_d;
      pend_dp_q    <= pend_dp_d;
      pend_lz_q    <= pend_lz_d;
      pend_full_q  <= pend_full_d;
    end
  end

  assign load_ready = !pend_full_q;
  assign seg_n      = seg_n_q;
  assign an_n       = an_n_q;
  assign digit_idx  = digit_idx_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
module tb_seven_seg_scan_ctrl;

  logic        clk;
  logic        rst;
  logic        enable;
  logic        load_valid;
  logic        load_ready;
  logic [15:0] value_in;
  logic [3:0]  dp_in;
  logic        lz_blank_en;
  logic [7:0]  seg_n;
  logic [3:0]  an_n;
  logic [1:0]  digit_idx;
  logic        frame_done;

  int errors = 0;
  int checks = 0;

  seven_seg_scan_ctrl #(
    .NUM_DIGITS  (4),
    .DIGIT_TICKS (4),
    .BLANK_TICKS (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .load_valid  (load_valid),
    .load_ready  (load_ready),
    .value_in    (value_in),
    .dp_in       (dp_in),
    .lz_blank_en (lz_blank_en),
    .seg_n       (seg_n),
    .an_n        (an_n),
    .digit_idx   (digit_idx),
    .frame_done  (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Load a word while idle: one edge to accept, one edge to promote.
  task automatic load_idle(input logic [15:0] v, input logic [3:0] dp, input logic lz);
    value_in    = v;
    dp_in       = dp;
    lz_blank_en = lz;
    load_valid  = 1'b1;
    tick();
    load_valid  = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    #2;
    rst = 1'b1;
    #1;
    checks++; if (seg_n !== 8'hFF) begin errors++; $display("FAIL reset seg_n got %h want ff", seg_n); end
    checks++; if (an_n !== 4'hF) begin errors++; $display("FAIL reset an_n got %h want f", an_n); end
    checks++; if (load_ready !== 1'b1) begin errors++; $display("FAIL reset load_ready got %b want 1", load_ready); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset frame_done got %b want 0", frame_done); end
    checks++; if (digit_idx !== 2'd0) begin errors++; $display("FAIL reset digit_idx got %0d want 0", digit_idx); end
    tick();
    checks++; if (an_n !== 4'hF) begin errors++; $display("FAIL reset_held an_n got %h want f", an_n); end
    @(negedge clk);
    rst = 1'b0;
    tick();
  endtask

  task automatic test_load_idle();
    logic [7:0] tbl [4];
    logic [3:0] exp_an;
    logic [7:0] exp_seg;
    int slot, pos;
    tbl[0] = 8'hC0; tbl[1] = 8'h88; tbl[2] = 8'hA4; tbl[3] = 8'hF9;
    value_in   = 16'h12A0;
    dp_in      = 4'b0000;
    lz_blank_en = 1'b0;
    load_valid = 1'b1;
    tick();
    checks++; if (load_ready !== 1'b0) begin errors++; $display("FAIL load_idle ready_after_accept got %b want 0", load_ready); end
    load_valid = 1'b0;
    tick();
    checks++; if (load_ready !== 1'b1) begin errors++; $display("FAIL load_idle ready_after_xfer got %b want 1", load_ready); end
    enable = 1'b1;
    for (int k = 0; k < 48; k++) begin
      tick();
      slot = (k % 24) / 6;
      pos  = k % 6;
      exp_an  = 4'hF;
      exp_seg = 8'hFF;
      if (pos >= 2) begin
        exp_an[slot] = 1'b0;
        exp_seg = tbl[slot];
      end
      checks++; if (an_n !== exp_an) begin errors++; $display("FAIL load_idle an_n k=%0d got %b want %b", k, an_n, exp_an); end
      checks++; if (seg_n !== exp_seg) begin errors++; $display("FAIL load_idle seg_n k=%0d got %h want %h", k, seg_n, exp_seg); end
      checks++; if (digit_idx !== 2'(slot)) begin errors++; $display("FAIL load_idle digit_idx k=%0d got %0d want %0d", k, digit_idx, slot); end
      checks++; if (frame_done !== (k == 24)) begin errors++; $display("FAIL load_idle frame_done k=%0d got %b want %b", k, frame_done, (k == 24)); end
    end
    enable = 1'b0;
    tick();
    checks++; if (an_n !== 4'hF) begin errors++; $display("FAIL load_idle stop an_n got %b want 1111", an_n); end
  endtask

  task automatic test_lz_blank();
    logic [7:0] tbl_on [4];
    logic [7:0] tbl_off [4];
    logic [7:0] exp_seg;
    int slot, pos;
    tbl_on[0]  = 8'hC0; tbl_on[1]  = 8'h92; tbl_on[2]  = 8'h7F; tbl_on[3]  = 8'hFF;
    tbl_off[0] = 8'hC0; tbl_off[1] = 8'h92; tbl_off[2] = 8'h40; tbl_off[3] = 8'hC0;
    load_idle(16'h0050, 4'b0100, 1'b1);
    enable = 1'b1;
    for (int k = 0; k < 48; k++) begin
      tick();
      slot = (k % 24) / 6;
      pos  = k % 6;
      exp_seg = 8'hFF;
      if (pos >= 2) exp_seg = (k < 24) ? tbl_on[slot] : tbl_off[slot];
      checks++; if (seg_n !== exp_seg) begin errors++; $display("FAIL lz_blank seg_n k=%0d got %h want %h", k, seg_n, exp_seg); end
      if (k == 8) begin
        value_in    = 16'h0050;
        dp_in       = 4'b0100;
        lz_blank_en = 1'b0;
        load_valid  = 1'b1;
      end
      if (k == 9) begin
        checks++; if (load_ready !== 1'b0) begin errors++; $display("FAIL lz_blank reload_ready got %b want 0", load_ready); end
        load_valid = 1'b0;
      end
    end
    enable = 1'b0;
    tick();
  endtask

  task automatic test_backpressure();
    logic [7:0] frame_seg [3];
    logic [7:0] exp_seg;
    logic exp_rdy;
    int slot, pos;
    frame_seg[0] = 8'hC0; frame_seg[1] = 8'hF9; frame_seg[2] = 8'hA4;
    load_idle(16'h0000, 4'b0000, 1'b0);
    enable = 1'b1;
    for (int k = 0; k < 72; k++) begin
      tick();
      slot = (k % 24) / 6;
      pos  = k % 6;
      exp_seg = (pos >= 2) ? frame_seg[k / 24] : 8'hFF;
      exp_rdy = (k < 4) || (k == 24) || (k >= 48);
      checks++; if (seg_n !== exp_seg) begin errors++; $display("FAIL backpressure seg_n k=%0d slot=%0d got %h want %h", k, slot, seg_n, exp_seg); end
      checks++; if (load_ready !== exp_rdy) begin errors++; $display("FAIL backpressure load_ready k=%0d got %b want %b", k, load_ready, exp_rdy); end
      if (k == 24) begin
        checks++; if (frame_done !== 1'b1) begin errors++; $display("FAIL backpressure frame_done k=24 got %b want 1", frame_done); end
      end
      if (k == 3) begin
        value_in   = 16'h1111;
        load_valid = 1'b1;
      end
      if (k == 4) value_in = 16'h2222;
      if (k == 25) load_valid = 1'b0;
    end
    enable = 1'b0;
    tick();
  endtask

  task automatic test_async_reset();
    logic [3:0] exp_an;
    logic [7:0] exp_seg;
    int slot, pos;
    enable = 1'b1;
    for (int k = 0; k <= 14; k++) tick();
    checks++; if (an_n !== 4'b1011) begin errors++; $display("FAIL async_reset pre an_n got %b want 1011", an_n); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (an_n !== 4'hF) begin errors++; $display("FAIL async_reset an_n got %b want 1111", an_n); end
    checks++; if (seg_n !== 8'hFF) begin errors++; $display("FAIL async_reset seg_n got %h want ff", seg_n); end
    checks++; if (digit_idx !== 2'd0) begin errors++; $display("FAIL async_reset digit_idx got %0d want 0", digit_idx); end
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 24; k++) begin
      tick();
      slot = k / 6;
      pos  = k % 6;
      exp_an  = 4'hF;
      exp_seg = 8'hFF;
      if (pos >= 2) begin
        exp_an[slot] = 1'b0;
        exp_seg = 8'hC0;
      end
      checks++; if (an_n !== exp_an) begin errors++; $display("FAIL async_reset restart an_n k=%0d got %b want %b", k, an_n, exp_an); end
      checks++; if (seg_n !== exp_seg) begin errors++; $display("FAIL async_reset restart seg_n k=%0d got %h want %h", k, seg_n, exp_seg); end
    end
  endtask

  task automatic test_enable_drop();
    enable = 1'b0;
    tick();
    enable = 1'b1;
    for (int k = 0; k <= 8; k++) tick();
    checks++; if (an_n !== 4'b1101) begin errors++; $display("FAIL enable_drop pre an_n got %b want 1101", an_n); end
    checks++; if (digit_idx !== 2'd1) begin errors++; $display("FAIL enable_drop pre digit_idx got %0d want 1", digit_idx); end
    enable = 1'b0;
    tick();
    checks++; if (an_n !== 4'hF) begin errors++; $display("FAIL enable_drop an_n got %b want 1111", an_n); end
    checks++; if (digit_idx !== 2'd0) begin errors++; $display("FAIL enable_drop digit_idx got %0d want 0", digit_idx); end
    checks++; if (seg_n !== 8'hFF) begin errors++; $display("FAIL enable_drop seg_n got %h want ff", seg_n); end
    tick();
    enable = 1'b1;
    tick();
    checks++; if (an_n !== 4'hF) begin errors++; $display("FAIL enable_drop re0 an_n got %b want 1111", an_n); end
    tick();
    checks++; if (an_n !== 4'hF) begin errors++; $display("FAIL enable_drop re1 an_n got %b want 1111", an_n); end
    tick();
    checks++; if (an_n !== 4'b1110) begin errors++; $display("FAIL enable_drop re2 an_n got %b want 1110", an_n); end
    checks++; if (digit_idx !== 2'd0) begin errors++; $display("FAIL enable_drop re2 digit_idx got %0d want 0", digit_idx); end
    enable = 1'b0;
    tick();
  endtask

  initial begin
    rst         = 1'b0;
    enable      = 1'b0;
    load_valid  = 1'b0;
    value_in    = 16'h0000;
    dp_in       = 4'b0000;
    lz_blank_en = 1'b0;
    test_reset();
    test_load_idle();
    test_lz_blank();
    test_backpressure();
    test_async_reset();
    test_enable_drop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
